// File: rtl/bram_dp_pipelined.sv
// rtl/bram_dp_pipelined.sv - true dual-port BRAM with lane write enables, read pipeline and credit-managed response FIFOs
module bram_dp_pipelined #(
    parameter int dataWidth   = 36,
    parameter int addrWidth   = 9,
    parameter int depth       = 1 << addrWidth,
    parameter int numLanes    = 4,
    parameter int readLatency = 2,
    parameter int respDepth   = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ena,
    input  logic                 enb,
    input  logic                 wea,
    input  logic                 web,
    input  logic [numLanes-1:0]  bea,
    input  logic [numLanes-1:0]  beb,
    input  logic [addrWidth-1:0] addra,
    input  logic [addrWidth-1:0] addrb,
    input  logic [dataWidth-1:0] dia,
    input  logic [dataWidth-1:0] dib,
    output logic                 rdya,
    output logic                 rdyb,
    output logic                 rdyRespa,
    output logic                 rdyRespb,
    input  logic                 deqa,
    input  logic                 deqb,
    output logic [dataWidth-1:0] doa,
    output logic [dataWidth-1:0] dob
);
    localparam int W  = dataWidth / numLanes;
    localparam int NS = readLatency - 1;
    localparam int CW = $clog2(respDepth + 1);
    localparam int PW = (respDepth > 1) ? $clog2(respDepth) : 1;

    logic [1:0]           en, we, deq, rdy_v, resp_v;
    logic [numLanes-1:0]  be   [2];
    logic [addrWidth-1:0] addr [2];
    logic [dataWidth-1:0] di   [2];
    logic [dataWidth-1:0] dout [2];
    logic [dataWidth-1:0] ram  [depth];

    assign en      = {enb, ena};
    assign we      = {web, wea};
    assign deq     = {deqb, deqa};
    assign be[0]   = bea;
    assign be[1]   = beb;
    assign addr[0] = addra;
    assign addr[1] = addrb;
    assign di[0]   = dia;
    assign di[1]   = dib;

    assign rdya     = rdy_v[0];
    assign rdyb     = rdy_v[1];
    assign rdyRespa = resp_v[0];
    assign rdyRespb = resp_v[1];
    assign doa      = dout[0];
    assign dob      = dout[1];

    // Port B lanes are written first so port A overrides them on a same-address collision.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int p = 1; p >= 0; p--) begin
                for (int i = 0; i < numLanes; i++) begin
                    if (en[p] && we[p] && be[p][i])
                        ram[addr[p]][i*W +: W] <= di[p][i*W +: W];
                end
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic                 acc, deq_ok, push;
        logic [NS-1:0]        pv;
        logic [dataWidth-1:0] pd [NS];
        logic [CW-1:0]        cnt, occ;
        logic [PW-1:0]        wp, rp;
        logic [dataWidth-1:0] fm [respDepth];

        // A credit is held from accept until dequeue, so the FIFO can never overflow.
        assign rdy_v[p]  = !RST && (cnt < CW'(respDepth));
        assign acc       = en[p] && !we[p] && rdy_v[p];
        assign resp_v[p] = (occ != '0);
        assign deq_ok    = deq[p] && resp_v[p];
        assign push      = pv[NS-1];
        assign dout[p]   = resp_v[p] ? fm[rp] : '0;

        always_ff @(posedge CLK) begin
            if (RST) begin
                pv  <= '0;
                cnt <= '0;
                occ <= '0;
                wp  <= '0;
                rp  <= '0;
            end else begin
                pv[0] <= acc;
                for (int i = 1; i < NS; i++) pv[i] <= pv[i-1];
                if (acc && !deq_ok)      cnt <= cnt + CW'(1);
                else if (!acc && deq_ok) cnt <= cnt - CW'(1);
                if (push && !deq_ok)      occ <= occ + CW'(1);
                else if (!push && deq_ok) occ <= occ - CW'(1);
                if (push)   wp <= (wp == PW'(respDepth - 1)) ? '0 : wp + PW'(1);
                if (deq_ok) rp <= (rp == PW'(respDepth - 1)) ? '0 : rp + PW'(1);
            end
        end

        always_ff @(posedge CLK) begin
            pd[0] <= ram[addr[p]];
            for (int i = 1; i < NS; i++) pd[i] <= pd[i-1];
            if (push) fm[wp] <= pd[NS-1];
        end
    end
endmodule

// File: tb/tb_bram_dp_pipelined.sv
// tb/tb_bram_dp_pipelined.sv - scoreboard bench for bram_dp_pipelined
module tb_bram_dp_pipelined;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ena = 0, enb = 0, wea = 0, web = 0, deqa = 0, deqb = 0;
    logic [3:0]  bea = 0, beb = 0;
    logic [8:0]  addra = 0, addrb = 0;
    logic [35:0] dia = 0, dib = 0;
    logic        rdya, rdyb, rdyRespa, rdyRespb;
    logic [35:0] doa, dob;

    int checks = 0;
    int errors = 0;
    logic [35:0] qa[$];
    logic [35:0] qb[$];

    bram_dp_pipelined #(
        .dataWidth(36), .addrWidth(9), .depth(512),
        .numLanes(4), .readLatency(2), .respDepth(4)
    ) dut (
        .CLK(CLK), .RST(RST),
        .ena(ena), .enb(enb), .wea(wea), .web(web),
        .bea(bea), .beb(beb), .addra(addra), .addrb(addrb),
        .dia(dia), .dib(dib),
        .rdya(rdya), .rdyb(rdyb), .rdyRespa(rdyRespa), .rdyRespb(rdyRespb),
        .deqa(deqa), .deqb(deqb), .doa(doa), .dob(dob)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response consumed by the DUT is compared against the scoreboard.
    always @(negedge CLK) begin
        if (!RST && rdyRespa && deqa) begin
            if (qa.size() == 0) chk("a_unexpected_resp", doa, 36'hx);
            else chk("a_resp", doa, qa.pop_front());
        end
        if (!RST && rdyRespb && deqb) begin
            if (qb.size() == 0) chk("b_unexpected_resp", dob, 36'hx);
            else chk("b_resp", dob, qb.pop_front());
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_a(input logic e, input logic w, input logic [3:0] b, input logic [8:0] a, input logic [35:0] d);
        ena = e; wea = w; bea = b; addra = a; dia = d;
    endtask

    task automatic set_b(input logic e, input logic w, input logic [3:0] b, input logic [8:0] a, input logic [35:0] d);
        enb = e; web = w; beb = b; addrb = a; dib = d;
    endtask

    task automatic idle;
        ena = 0; enb = 0; wea = 0; web = 0;
    endtask

    task automatic wr_a(input logic [8:0] a, input logic [35:0] d, input logic [3:0] b);
        set_a(1, 1, b, a, d); tick; idle;
    endtask

    task automatic wr_b(input logic [8:0] a, input logic [35:0] d, input logic [3:0] b);
        set_b(1, 1, b, a, d); tick; idle;
    endtask

    task automatic rd_a(input logic [8:0] a, input logic [35:0] exp);
        chk("rdya_before_read", {35'd0, rdya}, 36'd1);
        qa.push_back(exp);
        set_a(1, 0, 4'h0, a, 36'd0); tick; idle;
    endtask

    task automatic rd_b(input logic [8:0] a, input logic [35:0] exp);
        chk("rdyb_before_read", {35'd0, rdyb}, 36'd1);
        qb.push_back(exp);
        set_b(1, 0, 4'h0, a, 36'd0); tick; idle;
    endtask

    task automatic drain_a(output int n);
        n = 0;
        deqa = 1;
        while (qa.size() != 0 && n < 50) begin tick; n++; end
        deqa = 0;
        chk("drain_a_empty", 36'(qa.size()), 36'd0);
    endtask

    task automatic drain_b(output int n);
        n = 0;
        deqb = 1;
        while (qb.size() != 0 && n < 50) begin tick; n++; end
        deqb = 0;
        chk("drain_b_empty", 36'(qb.size()), 36'd0);
    endtask

    initial begin
        int n;
        // Reset state
        tick; tick; tick;
        chk("rst_rdya", {35'd0, rdya}, 36'd0);
        chk("rst_rdyb", {35'd0, rdyb}, 36'd0);
        chk("rst_rdyRespa", {35'd0, rdyRespa}, 36'd0);
        chk("rst_doa", doa, 36'd0);
        RST = 0;
        #1;
        chk("rdya_after_rst", {35'd0, rdya}, 36'd1);
        chk("rdyb_after_rst", {35'd0, rdyb}, 36'd1);

        // 1: full write then read, latency two edges
        wr_a(9'd5, 36'h123456789, 4'hF);
        rd_a(9'd5, 36'h123456789);
        chk("t1_no_resp_after_accept", {35'd0, rdyRespa}, 36'd0);
        tick;
        chk("t1_resp_valid", {35'd0, rdyRespa}, 36'd1);
        chk("t1_resp_data", doa, 36'h123456789);
        drain_a(n);

        // 2: single-lane write and a be=0 no-op
        wr_a(9'd5, 36'h0000000AB, 4'h1);
        wr_a(9'd5, 36'hFFFFFFFFF, 4'h0);
        rd_a(9'd5, 36'h1234566AB);
        drain_a(n);

        // 3: credit exhaustion on B, dropped read, credit return
        for (int i = 0; i < 5; i++) wr_b(9'(10 + i), 36'hB00000000 + 36'(i), 4'hF);
        for (int i = 0; i < 4; i++) rd_b(9'(10 + i), 36'hB00000000 + 36'(i));
        chk("t3_rdyb_full", {35'd0, rdyb}, 36'd0);
        set_b(1, 0, 4'h0, 9'd14, 36'd0); tick; idle;
        chk("t3_rdyb_still_full", {35'd0, rdyb}, 36'd0);
        tick; tick;
        chk("t3_head_valid", {35'd0, rdyRespb}, 36'd1);
        chk("t3_head_data", dob, 36'hB00000000);
        deqb = 1; tick; deqb = 0;
        chk("t3_rdyb_returns", {35'd0, rdyb}, 36'd1);
        drain_b(n);
        tick; tick; tick;
        chk("t3_no_dropped_resp", {35'd0, rdyRespb}, 36'd0);

        // 4: back-to-back reads with deq held
        for (int i = 0; i < 8; i++) wr_a(9'(20 + i), 36'hC00000000 + 36'(i * 3), 4'hF);
        deqa = 1;
        for (int i = 0; i < 8; i++) begin
            chk("t4_rdya_held", {35'd0, rdya}, 36'd1);
            qa.push_back(36'hC00000000 + 36'(i * 3));
            set_a(1, 0, 4'h0, 9'(20 + i), 36'd0); tick;
        end
        idle;
        drain_a(n);
        chk("t4_drain_cycles", 36'(n), 36'd2);

        // 5: collisions on addr 7
        set_a(1, 1, 4'hF, 9'd7, 36'hAAAAAAAAA);
        set_b(1, 1, 4'hF, 9'd7, 36'h555555555);
        tick; idle;
        qa.push_back(36'hAAAAAAAAA);
        set_a(1, 0, 4'h0, 9'd7, 36'd0);
        set_b(1, 1, 4'hF, 9'd7, 36'd0);
        tick; idle;
        drain_a(n);
        rd_a(9'd7, 36'd0);
        drain_a(n);
        set_a(1, 1, 4'h3, 9'd7, 36'h111111111);
        set_b(1, 1, 4'hF, 9'd7, 36'h555555555);
        tick; idle;
        rd_a(9'd7, 36'h555551111);
        drain_a(n);
        qb.push_back(36'h555551111);
        set_b(1, 0, 4'h0, 9'd7, 36'd0);
        set_a(1, 1, 4'hF, 9'd7, 36'h0F0F0F0F0);
        tick; idle;
        drain_b(n);
        rd_b(9'd7, 36'h0F0F0F0F0);
        drain_b(n);

        // 6: reset with reads in flight; writes ignored during reset
        wr_a(9'd30, 36'h0DEADBEEF, 4'hF);
        set_a(1, 0, 4'h0, 9'd30, 36'd0);
        tick; tick; tick;
        idle;
        RST = 1;
        set_a(1, 1, 4'hF, 9'd30, 36'd0);
        tick;
        chk("t6_rst_rdyRespa", {35'd0, rdyRespa}, 36'd0);
        chk("t6_rst_doa", doa, 36'd0);
        chk("t6_rst_rdya", {35'd0, rdya}, 36'd0);
        tick;
        idle;
        RST = 0;
        #1;
        chk("t6_rdya_after_rst", {35'd0, rdya}, 36'd1);
        tick; tick; tick; tick;
        chk("t6_inflight_discarded", {35'd0, rdyRespa}, 36'd0);
        rd_a(9'd30, 36'h0DEADBEEF);
        drain_a(n);

        tick; tick; tick;
        chk("end_rdyRespa", {35'd0, rdyRespa}, 36'd0);
        chk("end_rdyRespb", {35'd0, rdyRespb}, 36'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
